// File: rtl/fifo_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_arbiter_if
// Bundles the read-side signals between the FIFO read-pointer logic, the
// consumers and the read arbiter.
//
// Handshake semantics:
//   - r_en is a pop strobe. It pops one word per cycle from the FIFO and is
//     only ever high while empty is low. rdata is taken in the same cycle.
//   - dout_vld is a plain valid with no ready. Each high cycle delivers exactly
//     one word on dout, owned by dout_id. Consumers must accept it.
//
// Modports:
//   master : the arbiter (drives r_en, gnt, dout, dout_vld, dout_id)
//   slave  : FIFO + consumers side (drives req, empty, rdata)
// -----------------------------------------------------------------------------
interface fifo_rd_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int IW   = $clog2(NREQ)
);
    logic [NREQ-1:0] req;
    logic            empty;
    logic [DW-1:0]   rdata;
    logic            r_en;
    logic [NREQ-1:0] gnt;
    logic [DW-1:0]   dout;
    logic            dout_vld;
    logic [IW-1:0]   dout_id;

    modport master (
        input  req, empty, rdata,
        output r_en, gnt, dout, dout_vld, dout_id
    );

    modport slave (
        output req, empty, rdata,
        input  r_en, gnt, dout, dout_vld, dout_id
    );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_rd_arbiter
// Round-robin read-side arbiter for the asynchronous FIFO (read clock domain).
// Grants the single FIFO read port to one consumer at a time for at most BURST
// pops, and returns every popped word one cycle later tagged with its owner.
//
// Ports:
//   rclk      : read-domain clock
//   rrst_n    : asynchronous active-low reset
//   bus       : fifo_rd_arbiter_if.master (req/empty/rdata in,
//               r_en/gnt/dout/dout_vld/dout_id out)
//   state_dbg : current FSM state (0 = IDLE, 1 = GRANT)
// -----------------------------------------------------------------------------
module fifo_rd_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4,
    parameter int IW    = $clog2(NREQ)
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    fifo_rd_arbiter_if.master     bus,
    output logic                  state_dbg
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam int         CW    = $clog2(BURST) + 1;

    logic [0:0]    state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last;
    logic [CW-1:0] cnt;

    logic [IW-1:0] winner;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;
    logic          hi_found;
    logic          r_en_c;
    logic          release_c;

    // Round-robin pick: the lowest requester above 'last' if one exists,
    // otherwise wrap around to the lowest requester overall. Scanning from the
    // top down lets the lowest matching index overwrite the others.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                lo_idx = IW'(i);
                if (i > int'(last)) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    // Pop only while granted, the owner still wants data and data exists.
    assign r_en_c    = (state == GRANT) && bus.req[owner] && !bus.empty;
    assign release_c = (r_en_c && (cnt == CW'(BURST - 1))) ||
                       !bus.req[owner] || bus.empty;

    assign bus.r_en  = r_en_c;
    assign state_dbg = state[0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state        <= IDLE;
            owner        <= '0;
            last         <= IW'(NREQ - 1);
            cnt          <= '0;
            bus.gnt      <= '0;
            bus.dout     <= '0;
            bus.dout_vld <= 1'b0;
            bus.dout_id  <= '0;
        end else begin
            bus.dout_vld <= r_en_c;
            if (r_en_c) begin
                bus.dout    <= bus.rdata;
                bus.dout_id <= owner;
            end

            case (state)
                IDLE: begin
                    if ((|bus.req) && !bus.empty) begin
                        owner   <= winner;
                        cnt     <= '0;
                        state   <= GRANT;
                        // gnt is loaded with the new owner so it is
                        // onehot(owner) for every GRANT cycle.
                        bus.gnt <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                    end
                end
                GRANT: begin
                    if (r_en_c) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (release_c) begin
                        state   <= IDLE;
                        last    <= owner;
                        bus.gnt <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus.gnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
module tb_fifo_rd_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;
    localparam int IW    = 2;

    logic rclk;
    logic rrst_n;
    logic state_dbg;

    fifo_rd_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    fifo_rd_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // FIFO model contents and scoreboard of expected {id, data}
    logic [DW-1:0]    fifo_q[$];
    logic [IW+DW-1:0] exp_q[$];

    // values sampled at the negedge of the current cycle
    logic            s_ren;
    logic [NREQ-1:0] s_gnt;
    logic            s_vld;
    logic [IW-1:0]   s_id;
    logic [DW-1:0]   s_dout;

    task automatic drive_fifo();
        bus.empty = (fifo_q.size() == 0);
        bus.rdata = bus.empty ? '0 : fifo_q[0];
    endtask

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
        drive_fifo();
    endtask

    // One cycle: sample at negedge, then after the edge apply the FIFO pop.
    task automatic tick();
        @(negedge rclk);
        s_ren  = bus.r_en;
        s_gnt  = bus.gnt;
        s_vld  = bus.dout_vld;
        s_id   = bus.dout_id;
        s_dout = bus.dout;
        @(posedge rclk);
        #1;
        if (s_ren && fifo_q.size() > 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic do_reset();
        rrst_n  = 1'b0;
        bus.req = '0;
        fifo_q.delete();
        exp_q.delete();
        drive_fifo();
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;
    endtask

    task automatic test_reset();
        rrst_n  = 1'b0;
        bus.req = 4'b1111;
        fifo_q.delete();
        load(2, 8'hA0);
        repeat (2) @(posedge rclk);
        #1;
        vec_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        vec_cnt++; if (bus.r_en !== 1'b0) begin err_cnt++; $display("FAIL reset_r_en got=%b exp=0", bus.r_en); end
        vec_cnt++; if (bus.dout_vld !== 1'b0) begin err_cnt++; $display("FAIL reset_vld got=%b exp=0", bus.dout_vld); end
        vec_cnt++; if (bus.dout !== 8'h00) begin err_cnt++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
        vec_cnt++; if (bus.dout_id !== 2'd0) begin err_cnt++; $display("FAIL reset_id got=%0d exp=0", bus.dout_id); end
        vec_cnt++; if (state_dbg !== 1'b0) begin err_cnt++; $display("FAIL reset_state got=%b exp=0", state_dbg); end
    endtask

    // req=0001, 6 words: burst of 4, one IDLE cycle, burst of 2 ended by empty
    task automatic test_single();
        logic [3:0] eg [10];
        logic       er [10];
        logic [IW+DW-1:0] e;
        eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
        er = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        bus.req = 4'b0001;
        load(6, 8'h10);
        for (int i = 0; i < 6; i++) exp_q.push_back({2'd0, 8'h10 + 8'(i)});
        for (int c = 0; c < 10; c++) begin
            tick();
            vec_cnt++; if (s_gnt !== eg[c]) begin err_cnt++; $display("FAIL single_gnt c=%0d got=%b exp=%b", c, s_gnt, eg[c]); end
            vec_cnt++; if (s_ren !== er[c]) begin err_cnt++; $display("FAIL single_r_en c=%0d got=%b exp=%b", c, s_ren, er[c]); end
            if (s_vld) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin err_cnt++; $display("FAIL single_vld c=%0d unexpected id=%0d dout=%h", c, s_id, s_dout); end
                else begin
                    e = exp_q.pop_front();
                    if ({s_id, s_dout} !== e) begin err_cnt++; $display("FAIL single_dout c=%0d got=%0d/%h exp=%0d/%h", c, s_id, s_dout, e[9:8], e[7:0]); end
                end
            end
        end
        vec_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL single_count missing=%0d exp=0", exp_q.size()); end
    endtask

    // req=1111, 16 words: grants 0,1,2,3 with 4 words each, 3 gap cycles
    task automatic test_all_rr();
        logic [3:0] eg [21];
        logic [IW+DW-1:0] e;
        eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0,
               4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0};
        do_reset();
        bus.req = 4'b1111;
        load(16, 8'h40);
        for (int i = 0; i < 16; i++) exp_q.push_back({2'(i / 4), 8'h40 + 8'(i)});
        for (int c = 0; c < 21; c++) begin
            tick();
            vec_cnt++; if (s_gnt !== eg[c]) begin err_cnt++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, s_gnt, eg[c]); end
            vec_cnt++; if (s_ren !== (eg[c] != 4'h0)) begin err_cnt++; $display("FAIL rr_r_en c=%0d got=%b exp=%b", c, s_ren, eg[c] != 4'h0); end
            if (s_vld) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin err_cnt++; $display("FAIL rr_vld c=%0d unexpected id=%0d dout=%h", c, s_id, s_dout); end
                else begin
                    e = exp_q.pop_front();
                    if ({s_id, s_dout} !== e) begin err_cnt++; $display("FAIL rr_dout c=%0d got=%0d/%h exp=%0d/%h", c, s_id, s_dout, e[9:8], e[7:0]); end
                end
            end
        end
        vec_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL rr_count missing=%0d exp=0", exp_q.size()); end
    endtask

    // req=0110, 12 words: 1 first (from last=3), then 2, then back to 1
    task automatic test_pair();
        logic [3:0] eg [16];
        logic [IW+DW-1:0] e;
        eg = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0,
               4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
        do_reset();
        bus.req = 4'b0110;
        load(12, 8'h80);
        for (int i = 0; i < 12; i++) exp_q.push_back({(i / 4 == 1) ? 2'd2 : 2'd1, 8'h80 + 8'(i)});
        for (int c = 0; c < 16; c++) begin
            tick();
            vec_cnt++; if (s_gnt !== eg[c]) begin err_cnt++; $display("FAIL pair_gnt c=%0d got=%b exp=%b", c, s_gnt, eg[c]); end
            vec_cnt++; if (s_ren !== (eg[c] != 4'h0)) begin err_cnt++; $display("FAIL pair_r_en c=%0d got=%b exp=%b", c, s_ren, eg[c] != 4'h0); end
            if (s_vld) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin err_cnt++; $display("FAIL pair_vld c=%0d unexpected id=%0d dout=%h", c, s_id, s_dout); end
                else begin
                    e = exp_q.pop_front();
                    if ({s_id, s_dout} !== e) begin err_cnt++; $display("FAIL pair_dout c=%0d got=%0d/%h exp=%0d/%h", c, s_id, s_dout, e[9:8], e[7:0]); end
                end
            end
        end
        vec_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL pair_count missing=%0d exp=0", exp_q.size()); end
    endtask

    // req=0011, owner 0 drops req after 2 reads; grant moves to 1
    task automatic test_drop();
        logic [3:0] eg [10];
        logic       er [10];
        logic [IW+DW-1:0] e;
        eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
        er = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        bus.req = 4'b0011;
        load(6, 8'hC0);
        for (int i = 0; i < 6; i++) exp_q.push_back({(i < 2) ? 2'd0 : 2'd1, 8'hC0 + 8'(i)});
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 2) bus.req = 4'b0010;
            vec_cnt++; if (s_gnt !== eg[c]) begin err_cnt++; $display("FAIL drop_gnt c=%0d got=%b exp=%b", c, s_gnt, eg[c]); end
            vec_cnt++; if (s_ren !== er[c]) begin err_cnt++; $display("FAIL drop_r_en c=%0d got=%b exp=%b", c, s_ren, er[c]); end
            if (s_vld) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin err_cnt++; $display("FAIL drop_vld c=%0d unexpected id=%0d dout=%h", c, s_id, s_dout); end
                else begin
                    e = exp_q.pop_front();
                    if ({s_id, s_dout} !== e) begin err_cnt++; $display("FAIL drop_dout c=%0d got=%0d/%h exp=%0d/%h", c, s_id, s_dout, e[9:8], e[7:0]); end
                end
            end
        end
        vec_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL drop_count missing=%0d exp=0", exp_q.size()); end
    endtask

    // FIFO empty with req=1111: no grant until a word arrives
    task automatic test_empty();
        logic [3:0] eg [7];
        logic       er [7];
        logic [IW+DW-1:0] e;
        eg = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0};
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        bus.req = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c == 2) begin
                load(1, 8'h5A);
                exp_q.push_back({2'd0, 8'h5A});
            end
            vec_cnt++; if (s_gnt !== eg[c]) begin err_cnt++; $display("FAIL empty_gnt c=%0d got=%b exp=%b", c, s_gnt, eg[c]); end
            vec_cnt++; if (s_ren !== er[c]) begin err_cnt++; $display("FAIL empty_r_en c=%0d got=%b exp=%b", c, s_ren, er[c]); end
            if (s_vld) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin err_cnt++; $display("FAIL empty_vld c=%0d unexpected id=%0d dout=%h", c, s_id, s_dout); end
                else begin
                    e = exp_q.pop_front();
                    if ({s_id, s_dout} !== e) begin err_cnt++; $display("FAIL empty_dout c=%0d got=%0d/%h exp=%0d/%h", c, s_id, s_dout, e[9:8], e[7:0]); end
                end
            end
        end
        vec_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL empty_count missing=%0d exp=0", exp_q.size()); end
    endtask

    // Reset asserted in cycle 2 of a burst; requester 0 wins again afterwards
    task automatic test_reset_mid();
        do_reset();
        bus.req = 4'b1111;
        load(8, 8'hE0);
        tick();
        tick();
        vec_cnt++; if (s_gnt !== 4'b0001) begin err_cnt++; $display("FAIL mid_pre_gnt got=%b exp=0001", s_gnt); end
        @(negedge rclk);
        vec_cnt++; if (bus.dout_vld !== 1'b1 || bus.dout !== 8'hE0) begin err_cnt++; $display("FAIL mid_pre_dout got=%b/%h exp=1/e0", bus.dout_vld, bus.dout); end
        vec_cnt++; if (bus.r_en !== 1'b1) begin err_cnt++; $display("FAIL mid_pre_r_en got=%b exp=1", bus.r_en); end
        #2;
        rrst_n = 1'b0;
        #1;
        vec_cnt++; if (bus.gnt !== 4'b0000) begin err_cnt++; $display("FAIL mid_gnt got=%b exp=0000", bus.gnt); end
        vec_cnt++; if (bus.r_en !== 1'b0) begin err_cnt++; $display("FAIL mid_r_en got=%b exp=0", bus.r_en); end
        vec_cnt++; if (bus.dout_vld !== 1'b0) begin err_cnt++; $display("FAIL mid_vld got=%b exp=0", bus.dout_vld); end
        vec_cnt++; if (state_dbg !== 1'b0) begin err_cnt++; $display("FAIL mid_state got=%b exp=0", state_dbg); end
        @(posedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
        tick();
        vec_cnt++; if (s_gnt !== 4'b0001) begin err_cnt++; $display("FAIL mid_regrant got=%b exp=0001", s_gnt); end
        vec_cnt++; if (s_ren !== 1'b1) begin err_cnt++; $display("FAIL mid_regrant_r_en got=%b exp=1", s_ren); end
        tick();
        vec_cnt++; if (s_vld !== 1'b1 || s_id !== 2'd0 || s_dout !== 8'hE1) begin err_cnt++; $display("FAIL mid_after_dout got=%b/%0d/%h exp=1/0/e1", s_vld, s_id, s_dout); end
    endtask

    initial begin
        rrst_n    = 1'b0;
        bus.req   = '0;
        bus.empty = 1'b1;
        bus.rdata = '0;
        test_reset();
        test_single();
        test_all_rr();
        test_pair();
        test_drop();
        test_empty();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
